// File: rtl/hash_probe_engine.sv
// Linear-probing hash lookup engine: hashes a 64-bit key, walks buckets from the home slot
// and returns hit/payload. Optional hit/miss counters are enabled by defining PROBE_STATS_EN.
module hash_probe_engine #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_PROBE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [63:0]       data_in,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [128:0]      rd_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              hit_out,
  output logic [63:0]       key_out,
  output logic [63:0]       payload_out
`ifdef PROBE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam logic [31:0] MUL_HI = 32'h1E698F65;
  localparam logic [31:0] MUL_LO = 32'h24820C8D;

  typedef enum logic [2:0] {IDLE, HASH, REQ, WAIT, OUT} state_t;

  state_t              state, state_nxt;
  logic [63:0]         key_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          probe_cnt;
  logic [8:0]          probe_inc;
  logic                last_probe;
  logic                hit_q;
  logic [63:0]         payload_q;
  logic [ADDR_W-1:0]   home;
  logic                occupied;
  logic                key_match;

  // Low ADDR_W bits of the 48-bit products/sum depend only on the low ADDR_W bits of
  // each operand, so the home bucket is computed directly at ADDR_W width.
  always_comb begin
    home = key_q[32 +: ADDR_W] * MUL_HI[ADDR_W-1:0]
         + key_q[0 +: ADDR_W]  * MUL_LO[ADDR_W-1:0];
  end

  always_comb begin
    occupied   = rd_data[128];
    key_match  = (rd_data[127:64] == key_q);
    probe_inc  = {1'b0, probe_cnt} + 9'd1;
    last_probe = (probe_inc == 9'(MAX_PROBE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_in) state_nxt = HASH;
      HASH: state_nxt = REQ;
      REQ:  if (rd_gnt) state_nxt = WAIT;
      WAIT: begin
        if (rd_valid) begin
          if (!occupied || key_match || last_probe) state_nxt = OUT;
          else                                      state_nxt = REQ;
        end
      end
      OUT:  if (ready_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      addr_q    <= '0;
      probe_cnt <= '0;
      hit_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) key_q <= data_in;
        HASH: begin
          addr_q    <= home;
          probe_cnt <= '0;
          hit_q     <= 1'b0;
          payload_q <= '0;
        end
        WAIT: begin
          if (rd_valid && occupied) begin
            if (key_match) begin
              hit_q     <= 1'b1;
              payload_q <= rd_data[63:0];
            end else begin
              probe_cnt <= probe_inc[7:0];
              if (!last_probe) addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_in    = (state == IDLE);
  assign rd_req      = (state == REQ);
  assign rd_addr     = addr_q;
  assign valid_out   = (state == OUT);
  assign hit_out     = hit_q;
  assign key_out     = key_q;
  assign payload_out = payload_q;

`ifdef PROBE_STATS_EN
  logic result_taken;
  assign result_taken = (state == OUT) && ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (result_taken) begin
      if (hit_q) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/hash_probe_engine.md
HASH_PROBE_ENGINE -- requirements
Module: hash_probe_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, bucket address width (1..31).
REQ-002 The block SHALL have parameter MAX_PROBE, default 8, maximum buckets examined per probe (1..255).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port valid_in  input  1  probe tuple present.
REQ-006 The block SHALL have port ready_in  output  1  block accepts probe tuple.
REQ-007 The block SHALL have port data_in  input  64  probe key.
REQ-008 The block SHALL have port rd_req  output  1  table read request.
REQ-009 The block SHALL have port rd_addr  output  ADDR_W  bucket address.
REQ-010 The block SHALL have port rd_gnt  input  1  read request accepted.
REQ-011 The block SHALL have port rd_valid  input  1  read response present.
REQ-012 The block SHALL have port rd_data  input  129  bucket {occupied[128], key[127:64], payload[63:0]}.
REQ-013 The block SHALL have port valid_out  output  1  result present.
REQ-014 The block SHALL have port ready_out  input  1  downstream accepts result.
REQ-015 The block SHALL have port hit_out  output  1  1 = key found, 0 = miss.
REQ-016 The block SHALL have port key_out  output  64  probe key echoed.
REQ-017 The block SHALL have port payload_out  output  64  matched payload; 0 on miss.

Function
REQ-018 The hash SHALL be h = (0x1E698F65*data_in[63:32] + 0x24820C8D*data_in[31:0]) mod 2^31, products and sum 48-bit; the home bucket SHALL be h[ADDR_W-1:0], bit-identical to the build-side hash.
REQ-019 The FSM SHALL have states IDLE, HASH, REQ, WAIT, OUT; one probe in flight at a time.
REQ-020 ready_in SHALL be 1 only in IDLE; valid_in&ready_in SHALL latch the key and go to HASH.
REQ-021 HASH SHALL register the home bucket in exactly one cycle, clear the probe counter, and go to REQ.
REQ-022 In REQ, rd_req SHALL be 1 with rd_addr stable until rd_gnt; on rd_gnt go to WAIT.
REQ-023 In WAIT, rd_valid SHALL be evaluated: occupied=0 -> miss, OUT; occupied=1 and key equal -> hit, capture payload, OUT; otherwise increment probe counter.
REQ-024 On a key mismatch, if the probe count reaches MAX_PROBE the FSM SHALL go to OUT with a miss, else it SHALL increment rd_addr modulo 2^ADDR_W (all-ones wraps to 0) and return to REQ.
REQ-025 rd_valid outside WAIT SHALL be ignored.
REQ-026 In OUT, valid_out SHALL be 1 with hit_out/key_out/payload_out stable until ready_out; on valid_out&ready_out go to IDLE.
REQ-027 Minimum latency from input acceptance to valid_out SHALL be 3 cycles plus memory latency (home-bucket hit, rd_gnt in first REQ cycle).

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, ready_in=1, rd_req=0, valid_out=0, hit_out=0, key_out=0, payload_out=0, rd_addr=0, probe counter=0.
REQ-029 A reset mid-probe SHALL abandon the probe; a response arriving after reset release SHALL be discarded per REQ-025.

Configuration
REQ-030 With macro PROBE_STATS_EN defined, the block SHALL add outputs hit_count[31:0] and miss_count[31:0], reset to 0, incremented on each accepted hit/miss result and saturating at 0xFFFFFFFF.
REQ-031 Without PROBE_STATS_EN, those ports and counters SHALL not exist and function is otherwise identical.

Verification
REQ-032 Key 0x0, bucket 0 = {1, 0x0, 0xAB} -> rd_addr 0x0000, hit_out=1, payload_out=0xAB.
REQ-033 Key 0x1, bucket 0x0C8D occupied=0 -> rd_addr 0x0C8D, one read, hit_out=0, payload_out=0.
REQ-034 Key 0x1, buckets 0x0C8D/0x0C8E occupied with other keys, 0x0C8F = {1, 0x1, 0x55} -> three reads, hit, payload 0x55.
REQ-035 Home bucket 0xFFFF occupied mismatch, 0x0000 matching -> second rd_addr 0x0000 (wrap), hit.
REQ-036 MAX_PROBE=8, all buckets occupied mismatch -> exactly 8 reads then miss; ready_out held 0 for 5 cycles -> outputs stable, ready_in=0.
REQ-037 rst_n pulsed low while in WAIT, late rd_valid after release -> no valid_out, ready_in=1; with PROBE_STATS_EN, counters read 0.
